hd44780_ctrl: RTL and testbench

Parametrised HD44780 character-LCD controller, the next generation of the fixed 4-bit driver. It runs from the system clock and derives its own 1 µs timebase, so no external clock divider is needed. It supports a 4- or 8-bit data bus, runs the datasheet power-on init sequence autonomously, then accepts command/data bytes over a valid/ready handshake. It sits between user logic (text/menu engines) and the LCD pins in `top`; RW is tied low externally.

---
 rtl/hd44780_pkg.sv | 39 +++
 rtl/hd44780_us_tick.sv | 34 +++
 rtl/hd44780_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_hd44780_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hd44780_pkg.sv
// rtl/hd44780_pkg.sv - shared states, instruction codes and timing constants for the HD44780 controller
package hd44780_pkg;

   typedef enum logic [2:0] {
      PWR_WAIT,
      INIT_LOAD,
      SETUP,
      E_HIGH,
      E_LOW,
      EXEC_WAIT,
      IDLE
   } state_t;

   localparam logic [7:0] CLEAR    = 8'h01;
   localparam logic [7:0] HOME     = 8'h02;
   localparam logic [7:0] ENTRY    = 8'h06;
   localparam logic [7:0] DISP_ON  = 8'h0C;
   localparam logic [7:0] DISP_OFF = 8'h08;
   localparam logic [7:0] FUNC_4B  = 8'h20;
   localparam logic [7:0] FUNC_8B  = 8'h30;
   localparam logic [7:0] N_BIT    = 8'h08;

   localparam logic [13:0] T_EXEC_US  = 14'd40;
   localparam logic [13:0] T_CLEAR_US = 14'd1640;
   localparam logic [13:0] T_INIT1_US = 14'd4100;
   localparam logic [13:0] T_INIT_US  = 14'd100;

   typedef struct packed {
      logic        nibble_only;
      logic [7:0]  data;
      logic [13:0] wait_us;
   } init_entry_t;

   // Clear/home (and 0x03, which decodes as home) need the long execution time.
   function automatic logic [13:0] exec_wait(input logic rs, input logic [7:0] data);
      return (!rs && (data == CLEAR || data == HOME || data == 8'h03)) ? T_CLEAR_US : T_EXEC_US;
   endfunction

endpackage

// File: rtl/hd44780_us_tick.sv
// rtl/hd44780_us_tick.sv - one-clock pulse every microsecond derived from the system clock
module hd44780_us_tick #(
   parameter int CLK_HZ = 27_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int DIV = CLK_HZ / 1_000_000;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   generate
      if (CLK_HZ < 1_000_000) begin : g_bad_clk
         $error("hd44780_us_tick: CLK_HZ must be at least 1 MHz");
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == CW'(DIV - 1)) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + 1'b1;
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/hd44780_ctrl.sv
// rtl/hd44780_ctrl.sv - HD44780 LCD controller: power-on init, then byte writes over valid/ready
module hd44780_ctrl
   import hd44780_pkg::*;
#(
   parameter int CLK_HZ     = 27_000_000,
   parameter int BUS_WIDTH  = 4,
   parameter int LINES      = 2,
   parameter int POWERUP_US = 15000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_rs,
   input  logic [7:0]           cmd_data,
   output logic                 busy,
   output logic                 e,
   output logic                 rs,
   output logic [BUS_WIDTH-1:0] db
);

   localparam logic [3:0]  INIT_LAST = (BUS_WIDTH == 8) ? 4'd7 : 4'd8;
   localparam logic [7:0]  FUNC_SET  = ((BUS_WIDTH == 8) ? FUNC_8B : FUNC_4B) | ((LINES == 2) ? N_BIT : 8'h00);
   localparam logic [13:0] PWR_LOAD  = 14'(POWERUP_US - 1);

   generate
      if (BUS_WIDTH != 4 && BUS_WIDTH != 8) begin : g_bad_bus
         $error("hd44780_ctrl: BUS_WIDTH must be 4 or 8");
      end
   endgenerate

   // 8-bit mode skips the 0x2 nibble entry, so indices from 3 up shift by one.
   function automatic init_entry_t init_rom(input logic [3:0] idx);
      logic [3:0]  k;
      init_entry_t ent;
      k = (BUS_WIDTH == 8 && idx >= 4'd3) ? idx + 4'd1 : idx;
      case (k)
         4'd0:       ent = '{1'b0, FUNC_8B,  T_INIT1_US};
         4'd1, 4'd2: ent = '{1'b0, FUNC_8B,  T_INIT_US};
         4'd3:       ent = '{1'b0, FUNC_4B,  T_INIT_US};
         4'd4:       ent = '{1'b0, FUNC_SET, T_EXEC_US};
         4'd5:       ent = '{1'b0, DISP_OFF, T_EXEC_US};
         4'd6:       ent = '{1'b0, CLEAR,    T_CLEAR_US};
         4'd7:       ent = '{1'b0, ENTRY,    T_EXEC_US};
         default:    ent = '{1'b0, DISP_ON,  T_EXEC_US};
      endcase
      ent.nibble_only = (BUS_WIDTH == 4) && (k < 4'd4);
      return ent;
   endfunction

   function automatic logic [7:0] bus_word(input logic [7:0] data, input logic low);
      if (BUS_WIDTH == 8) return data;
      return {4'h0, low ? data[3:0] : data[7:4]};
   endfunction

   state_t      state, state_n;
   logic [3:0]  idx, idx_n;
   logic        init_mode, init_mode_n;
   logic        cur_rs, cur_rs_n;
   logic [7:0]  cur_data, cur_data_n;
   logic        nib_only, nib_only_n;
   logic        low, low_n;
   logic [13:0] cur_wait, cur_wait_n;
   logic [13:0] dly, dly_n;
   logic        e_n, rs_n, cmd_ready_n;
   logic [7:0]  word_n;
   logic [BUS_WIDTH-1:0] db_n;
   logic        tick;
   init_entry_t rom;

   hd44780_us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign rom  = init_rom(idx);
   assign busy = !cmd_ready;

   always_comb begin
      state_n     = state;
      idx_n       = idx;
      init_mode_n = init_mode;
      cur_rs_n    = cur_rs;
      cur_data_n  = cur_data;
      nib_only_n  = nib_only;
      low_n       = low;
      cur_wait_n  = cur_wait;
      dly_n       = dly;
      case (state)
         PWR_WAIT: if (tick) begin
            if (dly == '0) begin
               state_n = INIT_LOAD;
               idx_n   = '0;
            end else begin
               dly_n = dly - 1'b1;
            end
         end
         INIT_LOAD: begin
            cur_rs_n   = 1'b0;
            cur_data_n = rom.data;
            nib_only_n = rom.nibble_only;
            cur_wait_n = rom.wait_us;
            low_n      = 1'b0;
            state_n    = SETUP;
         end
         SETUP:  if (tick) state_n = E_HIGH;
         E_HIGH: if (tick) state_n = E_LOW;
         E_LOW: if (tick) begin
            if (BUS_WIDTH == 4 && !nib_only && !low) begin
               low_n   = 1'b1;
               state_n = SETUP;
            end else begin
               dly_n   = cur_wait - 1'b1;
               state_n = EXEC_WAIT;
            end
         end
         EXEC_WAIT: if (tick) begin
            if (dly != '0) begin
               dly_n = dly - 1'b1;
            end else if (init_mode && idx != INIT_LAST) begin
               idx_n   = idx + 1'b1;
               state_n = INIT_LOAD;
            end else begin
               init_mode_n = 1'b0;
               state_n     = IDLE;
            end
         end
         IDLE: if (cmd_valid && cmd_ready) begin
            cur_rs_n   = cmd_rs;
            cur_data_n = cmd_data;
            nib_only_n = 1'b0;
            low_n      = 1'b0;
            cur_wait_n = exec_wait(cmd_rs, cmd_data);
            state_n    = SETUP;
         end
         default: state_n = PWR_WAIT;
      endcase

      // Pin values are decided from the next state so every output comes straight off a flop.
      e_n         = (state_n == E_HIGH);
      cmd_ready_n = (state_n == IDLE);
      rs_n        = rs;
      word_n      = '0;
      db_n        = db;
      if (state_n == SETUP) begin
         rs_n   = cur_rs_n;
         word_n = bus_word(cur_data_n, low_n);
         db_n   = word_n[BUS_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= PWR_WAIT;
         idx       <= '0;
         init_mode <= 1'b1;
         cur_rs    <= 1'b0;
         cur_data  <= '0;
         nib_only  <= 1'b0;
         low       <= 1'b0;
         cur_wait  <= '0;
         dly       <= PWR_LOAD;
         e         <= 1'b0;
         rs        <= 1'b0;
         db        <= '0;
         cmd_ready <= 1'b0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         init_mode <= init_mode_n;
         cur_rs    <= cur_rs_n;
         cur_data  <= cur_data_n;
         nib_only  <= nib_only_n;
         low       <= low_n;
         cur_wait  <= cur_wait_n;
         dly       <= dly_n;
         e         <= e_n;
         rs        <= rs_n;
         db        <= db_n;
         cmd_ready <= cmd_ready_n;
      end
   end

endmodule

// File: tb/tb_hd44780_ctrl.sv
// tb/tb_hd44780_ctrl.sv - scoreboard bench for hd44780_ctrl in 4-bit and 8-bit builds
module tb_hd44780_ctrl;

   localparam int CLK_HZ = 4_000_000;
   localparam int PWR_US = 20;
   localparam int LIMIT  = 30000;
   localparam int BIG    = 1 << 30;

   typedef struct {
      logic       rs;
      logic [7:0] db;
      int         gap;
   } pulse_t;

   logic       clk = 1'b0;
   logic       ra, rb;
   logic       a_valid, a_ready, a_rs_in, a_busy, a_e, a_rs;
   logic [7:0] a_data;
   logic [3:0] a_db;
   logic       b_valid, b_ready, b_rs_in, b_busy, b_e, b_rs;
   logic [7:0] b_data;
   logic [7:0] b_db;
   logic       a_eq = 1'b0, b_eq = 1'b0;

   pulse_t qa[$], qb[$];
   pulse_t xa, xb;
   int total = 0, bad = 0, cyc = 0;
   int a_rise = 0, a_fall = 0, b_rise = 0, b_fall = 0;
   int rel = 0, n = 0;

   always #5 clk = ~clk;

   hd44780_ctrl #(.CLK_HZ(CLK_HZ), .BUS_WIDTH(4), .LINES(2), .POWERUP_US(PWR_US)) dut_a (
      .clk(clk), .rst(ra), .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_rs(a_rs_in),
      .cmd_data(a_data), .busy(a_busy), .e(a_e), .rs(a_rs), .db(a_db));

   hd44780_ctrl #(.CLK_HZ(CLK_HZ), .BUS_WIDTH(8), .LINES(1), .POWERUP_US(PWR_US)) dut_b (
      .clk(clk), .rst(rb), .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_rs(b_rs_in),
      .cmd_data(b_data), .busy(b_busy), .e(b_e), .rs(b_rs), .db(b_db));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
      total++;
      assert (obs >= lo && obs <= hi) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic expa(input logic r, input logic [7:0] d, input int gap);
      qa.push_back('{r, d, gap});
   endtask

   task automatic expa_byte(input logic r, input logic [7:0] d, input int gap);
      expa(r, {4'h0, d[7:4]}, gap);
      expa(r, {4'h0, d[3:0]}, 8);
   endtask

   task automatic expb(input logic r, input logic [7:0] d, input int gap);
      qb.push_back('{r, d, gap});
   endtask

   task automatic push_init_a();
      expa(1'b0, 8'h03, PWR_US * 4);
      expa(1'b0, 8'h03, 4100 * 4);
      expa(1'b0, 8'h03, 100 * 4);
      expa(1'b0, 8'h02, 100 * 4);
      expa_byte(1'b0, 8'h28, 100 * 4);
      expa_byte(1'b0, 8'h08, 40 * 4);
      expa_byte(1'b0, 8'h01, 40 * 4);
      expa_byte(1'b0, 8'h06, 1640 * 4);
      expa_byte(1'b0, 8'h0C, 40 * 4);
   endtask

   task automatic push_init_b();
      expb(1'b0, 8'h30, PWR_US * 4);
      expb(1'b0, 8'h30, 4100 * 4);
      expb(1'b0, 8'h30, 100 * 4);
      expb(1'b0, 8'h30, 100 * 4);
      expb(1'b0, 8'h08, 40 * 4);
      expb(1'b0, 8'h01, 40 * 4);
      expb(1'b0, 8'h06, 1640 * 4);
      expb(1'b0, 8'h0C, 40 * 4);
   endtask

   task automatic wait_a_ready(input string tag);
      int k = 0;
      while (!a_ready && k < LIMIT) begin
         @(negedge clk);
         k++;
      end
      chk(tag, a_ready, 1'b1);
   endtask

   task automatic wait_b_ready(input string tag);
      int k = 0;
      while (!b_ready && k < LIMIT) begin
         @(negedge clk);
         k++;
      end
      chk(tag, b_ready, 1'b1);
   endtask

   task automatic send_a(input logic r, input logic [7:0] d, input int gap);
      a_valid = 1'b1;
      a_rs_in = r;
      a_data  = d;
      expa_byte(r, d, gap);
      @(negedge clk);
      a_valid = 1'b0;
      wait_a_ready("a_ready_after_byte");
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            cyc++;
            if (a_e && !a_eq) begin
               a_rise = cyc;
               chk("a_pulse_expected", qa.size() > 0, 1'b1);
               if (qa.size() > 0) begin
                  xa = qa.pop_front();
                  chk("a_rs", a_rs, xa.rs);
                  chk("a_db", a_db, xa.db[3:0]);
                  chk_rng("a_gap", cyc - a_fall, xa.gap, BIG);
               end
            end
            if (!a_e && a_eq) begin
               if (ra) chk("a_e_high_width", cyc - a_rise, 4);
               a_fall = cyc;
            end
            a_eq = a_e;
            if (b_e && !b_eq) begin
               b_rise = cyc;
               chk("b_pulse_expected", qb.size() > 0, 1'b1);
               if (qb.size() > 0) begin
                  xb = qb.pop_front();
                  chk("b_rs", b_rs, xb.rs);
                  chk("b_db", b_db, xb.db);
                  chk_rng("b_gap", cyc - b_fall, xb.gap, BIG);
               end
            end
            if (!b_e && b_eq) begin
               if (rb) chk("b_e_high_width", cyc - b_rise, 4);
               b_fall = cyc;
            end
            b_eq = b_e;
         end
      join_none

      ra = 1'b0; rb = 1'b0;
      a_valid = 1'b0; a_rs_in = 1'b0; a_data = 8'h00;
      b_valid = 1'b0; b_rs_in = 1'b0; b_data = 8'h00;
      repeat (3) @(negedge clk);
      chk("a_rst_e", a_e, 1'b0);
      chk("a_rst_rs", a_rs, 1'b0);
      chk("a_rst_db", a_db, 4'h0);
      chk("a_rst_ready", a_ready, 1'b0);
      chk("a_rst_busy", a_busy, 1'b1);
      chk("b_rst_ready", b_ready, 1'b0);
      chk("b_rst_db", b_db, 8'h00);

      ra = 1'b1; rb = 1'b1;
      rel = cyc; a_fall = cyc; b_fall = cyc;
      push_init_a();
      push_init_b();
      wait_a_ready("a_init_ready");
      chk_rng("a_first_ready", cyc - rel, 6220 * 4, BIG);
      wait_b_ready("b_init_ready");

      b_valid = 1'b1; b_rs_in = 1'b1; b_data = 8'hA5;
      expb(1'b1, 8'hA5, 40 * 4);
      @(negedge clk);
      b_valid = 1'b0;
      wait_b_ready("b_ready_after_a5");
      chk_rng("b_lat_a5", cyc - b_fall, 160, 168);

      send_a(1'b1, 8'h41, 40 * 4);
      chk_rng("a_lat_41", cyc - a_fall, 160, 168);
      send_a(1'b0, 8'h01, 40 * 4);
      chk_rng("a_lat_clear", cyc - a_fall, 6560, 6570);
      send_a(1'b1, 8'h01, 1640 * 4);
      chk_rng("a_lat_data01", cyc - a_fall, 160, 168);

      a_valid = 1'b1; a_rs_in = 1'b1; a_data = 8'h48;
      expa_byte(1'b1, 8'h48, 40 * 4);
      @(negedge clk);
      a_data = 8'h49;
      expa_byte(1'b1, 8'h49, 40 * 4);
      wait_a_ready("a_b2b_ready1");
      @(negedge clk);
      a_valid = 1'b0;
      wait_a_ready("a_b2b_ready2");
      chk("a_b2b_drained", qa.size(), 0);

      a_valid = 1'b1; a_rs_in = 1'b1; a_data = 8'h48;
      expa(1'b1, 8'h04, 40 * 4);
      @(negedge clk);
      a_valid = 1'b0;
      n = 0;
      while (!a_e && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      chk("a_e_before_abort", a_e, 1'b1);
      #1 ra = 1'b0;
      #1;
      chk("a_abort_e", a_e, 1'b0);
      chk("a_abort_rs", a_rs, 1'b0);
      chk("a_abort_db", a_db, 4'h0);
      chk("a_abort_ready", a_ready, 1'b0);
      chk("a_abort_busy", a_busy, 1'b1);
      repeat (4) @(negedge clk);
      ra = 1'b1;
      rel = cyc; a_fall = cyc;
      push_init_a();
      wait_a_ready("a_reinit_ready");
      chk_rng("a_reinit_time", cyc - rel, 6220 * 4, BIG);

      repeat (10) @(negedge clk);
      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
